// File: rtl/dram_ctrl_if.sv
// Single-word request/response bus between the DSP address generator and dram_ctrl.
interface dram_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [13:0] req_addr;
  logic [15:0] req_wdata;
  logic        rd_valid;
  logic [15:0] rd_data;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rd_valid, rd_data
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rd_valid, rd_data
  );
endinterface

// File: rtl/dram_ctrl.sv
// RAS/CAS sequencer for the reverb delay DRAM: early-write single-word accesses
// with RAS-only refresh interleaved on a free-running interval timer.
module dram_ctrl #(
  parameter int T_RCD        = 1,
  parameter int T_CAS        = 2,
  parameter int T_RP         = 2,
  parameter int T_RFR        = 3,
  parameter int REF_INTERVAL = 250
) (
  input  logic        clk,
  input  logic        reset,
  dram_ctrl_if.slave  bus,
  output logic        ref_overrun,
  output logic        nras,
  output logic        ncas,
  output logic        nwe,
  output logic        ng,
  output logic [7:0]  a,
  output logic [15:0] dq_out,
  output logic        dq_oe,
  input  logic [15:0] dq_in
);

  typedef enum logic [2:0] {IDLE, RADDR, ROW, COLA, CAS, PRE, REFA, REFRAS} state_t;

  localparam int CW = 8;
  localparam int TW = $clog2(REF_INTERVAL);

  state_t          state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [TW-1:0]   timer;
  logic [7:0]      ref_row;
  logic            ref_pend, ref_pend_nx;
  logic            we_q, we_nx;
  logic [13:0]     addr_q, addr_nx;
  logic [15:0]     wdata_q, wdata_nx;
  logic            ready_q, rd_valid_q;
  logic [15:0]     rd_data_q;
  logic            accept, tick, ref_exit, rd_done;

  logic            nras_d, ncas_d, nwe_d, ng_d, dq_oe_d;
  logic [7:0]      a_d;
  logic [15:0]     dq_out_d;

  // Residency minus one for the multi-cycle states; single-cycle states load 0.
  function automatic logic [CW-1:0] dur(state_t s);
    case (s)
      ROW:     return CW'(T_RCD - 1);
      CAS:     return CW'(T_CAS - 1);
      PRE:     return CW'(T_RP - 1);
      REFRAS:  return CW'(T_RFR - 1);
      default: return '0;
    endcase
  endfunction

  assign accept   = (state == IDLE) && bus.req_valid && ready_q && !ref_pend;
  assign tick     = (timer == TW'(REF_INTERVAL - 1));
  assign ref_exit = (state == REFRAS) && (cnt == '0);
  assign rd_done  = (state == CAS) && (cnt == '0) && !we_q;

  assign ref_pend_nx = tick | (ref_pend & ~ref_exit);
  assign we_nx       = accept ? bus.req_we    : we_q;
  assign addr_nx     = accept ? bus.req_addr  : addr_q;
  assign wdata_nx    = accept ? bus.req_wdata : wdata_q;

  assign bus.req_ready = ready_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rd_data_q;

  // State register plus the bookkeeping that shares its timing.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      timer       <= '0;
      ref_row     <= '0;
      ref_pend    <= 1'b0;
      ref_overrun <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      ready_q     <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      timer       <= tick ? '0 : timer + 1'b1;
      ref_row     <= ref_row + 8'(ref_exit);
      ref_pend    <= ref_pend_nx;
      ref_overrun <= ref_overrun | (tick & ref_pend);
      we_q        <= we_nx;
      addr_q      <= addr_nx;
      wdata_q     <= wdata_nx;
      ready_q     <= (state_nx == IDLE) && !ref_pend_nx;
      rd_valid_q  <= rd_done;
      if (rd_done) rd_data_q <= dq_in;
    end
  end

  // Next state and residency counter.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_nx = state;
    case (state)
      IDLE:    if (ref_pend) state_nx = REFA;
               else if (accept) state_nx = RADDR;
      RADDR:   state_nx = ROW;
      ROW:     if (cnt == '0) state_nx = COLA;
      COLA:    state_nx = CAS;
      CAS:     if (cnt == '0) state_nx = PRE;
      PRE:     if (cnt == '0) state_nx = IDLE;
      REFA:    state_nx = REFRAS;
      REFRAS:  if (cnt == '0) state_nx = PRE;
      default: state_nx = IDLE;
    endcase

    cnt_nx = cnt;
    if (state_nx != state) cnt_nx = dur(state_nx);
    else if (cnt != '0)    cnt_nx = cnt - 1'b1;
  end

  // Pin values for the state being entered, registered below.
  always_comb begin
    nras_d   = 1'b1;
    ncas_d   = 1'b1;
    nwe_d    = 1'b1;
    ng_d     = 1'b1;
    dq_oe_d  = 1'b0;
    a_d      = a;
    dq_out_d = dq_out;
    case (state_nx)
      RADDR: a_d = addr_nx[7:0];
      ROW: begin
        nras_d = 1'b0;
        a_d    = addr_nx[7:0];
      end
      COLA, CAS: begin
        nras_d = 1'b0;
        ncas_d = (state_nx == COLA);
        a_d    = {1'b0, addr_nx[13:8], 1'b0};
        if (we_nx) begin
          nwe_d    = 1'b0;
          dq_oe_d  = 1'b1;
          dq_out_d = wdata_nx;
        end else if (state_nx == CAS) begin
          ng_d = 1'b0;
        end
      end
      REFA:    a_d = ref_row;
      REFRAS:  nras_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      nras   <= 1'b1;
      ncas   <= 1'b1;
      nwe    <= 1'b1;
      ng     <= 1'b1;
      dq_oe  <= 1'b0;
      a      <= '0;
      dq_out <= '0;
    end else begin
      nras   <= nras_d;
      ncas   <= ncas_d;
      nwe    <= nwe_d;
      ng     <= ng_d;
      dq_oe  <= dq_oe_d;
      a      <= a_d;
      dq_out <= dq_out_d;
    end
  end

endmodule

// File: tb/tb_dram_ctrl.sv
// Randomized bench for dram_ctrl: pin-level DRAM model plus word-level reference memory,
// with separate instances for refresh ordering and refresh overrun.
module tb_dram_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- main instance, default timing ----------------
  logic        rst0;
  dram_ctrl_if bus0();
  logic        ovr0, nras0, ncas0, nwe0, ng0, oe0;
  logic [7:0]  a0;
  logic [15:0] dqo0, dqi0;

  dram_ctrl u_dut0 (
    .clk(clk), .reset(rst0), .bus(bus0), .ref_overrun(ovr0),
    .nras(nras0), .ncas(ncas0), .nwe(nwe0), .ng(ng0), .a(a0),
    .dq_out(dqo0), .dq_oe(oe0), .dq_in(dqi0)
  );

  // Pin-level DRAM: row on RAS fall, column on CAS fall, early write at CAS fall.
  logic [15:0] mem0 [0:16383];
  logic        p_nras0 = 1'b1, p_ncas0 = 1'b1, p_nwe0 = 1'b1;
  logic [7:0]  row0 = '0;
  logic [5:0]  col0 = '0;
  bit          cas_seen0 = 1'b0;
  int          ras_only0 = 0;

  always @(negedge clk) begin
    if (!nras0 && p_nras0) begin
      row0      = a0;
      cas_seen0 = 1'b0;
    end
    if (!ncas0 && p_ncas0) begin
      check("cas_under_ras", 32'(nras0), 32'd0);
      col0      = a0[6:1];
      cas_seen0 = 1'b1;
      if (!nwe0) begin
        check("early_we", 32'(p_nwe0), 32'd0);
        check("wr_oe", 32'(oe0), 32'd1);
        mem0[{col0, row0}] = dqo0;
      end
    end
    if (nras0 && !p_nras0 && !cas_seen0) ras_only0++;
    check("oe_g_excl", 32'(oe0 & ~ng0), 32'd0);
    dqi0    = (!nras0 && !ncas0 && !ng0) ? mem0[{col0, row0}] : 16'hDEAD;
    p_nras0 = nras0;
    p_ncas0 = ncas0;
    p_nwe0  = nwe0;
  end

  // Word-level reference: last value written per address.
  logic [15:0] ref_mem [int];
  time         acc_t = 0, prev_acc_t = 0;
  int          ras_at_acc = 0;

  task automatic req0(input logic we, input logic [13:0] addr, input logic [15:0] wd,
                      input bit keep, input bit chk_gap);
    int k;
    @(negedge clk);
    bus0.req_valid = 1'b1;
    bus0.req_we    = we;
    bus0.req_addr  = addr;
    bus0.req_wdata = wd;
    k = 0;
    while (!bus0.req_ready && k < 40) begin @(negedge clk); k++; end
    if (!bus0.req_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      bus0.req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    acc_t = $time;
    // Each RAS-only refresh between two accepts adds one refresh slot of 7 clocks.
    if (chk_gap)
      check("acc_gap", 32'((acc_t - prev_acc_t) / 10), 32'(8 + 7 * (ras_only0 - ras_at_acc)));
    prev_acc_t = acc_t;
    ras_at_acc = ras_only0;
    @(negedge clk);
    if (!keep) bus0.req_valid = 1'b0;
    if (we) begin
      ref_mem[int'(addr)] = wd;
    end else begin
      k = 0;
      while (!bus0.rd_valid && k < 40) begin @(negedge clk); k++; end
      if (!bus0.rd_valid) check("rd_timeout", 32'd0, 32'd1);
      else begin
        check("rd_latency", 32'(($time - 5 - acc_t) / 10), 32'd5);
        check("rd_data", 32'(bus0.rd_data), 32'(ref_mem[int'(addr)]));
      end
    end
  endtask

  // ---------------- refresh-ordering instance ----------------
  logic        rst1;
  dram_ctrl_if bus1();
  logic        ovr1, nras1, ncas1, nwe1, ng1, oe1;
  logic [7:0]  a1;
  logic [15:0] dqo1;
  logic [15:0] dqi1 = 16'h0;

  dram_ctrl #(.REF_INTERVAL(16)) u_dut1 (
    .clk(clk), .reset(rst1), .bus(bus1), .ref_overrun(ovr1),
    .nras(nras1), .ncas(ncas1), .nwe(nwe1), .ng(ng1), .a(a1),
    .dq_out(dqo1), .dq_oe(oe1), .dq_in(dqi1)
  );

  logic        p_nras1 = 1'b1, p_ncas1 = 1'b1;
  logic [7:0]  row1 = '0, exp_row1 = '0;
  bit          cas_seen1 = 1'b0, acc_pre1 = 1'b0;
  int          nref1 = 0, e1 = 0, ties1 = 0, tie_stage1 = 0;

  // Edge index since reset release; a tick lands on every 16th edge.
  always @(posedge clk) begin
    #1;
    if (rst1) e1 = 0;
    else begin
      e1++;
      if (e1 % 16 == 0 && acc_pre1 && tie_stage1 == 0) begin
        ties1++;
        tie_stage1 = 1;
      end
    end
  end

  always @(negedge clk) begin
    acc_pre1 = bus1.req_valid && bus1.req_ready;
    if (!nras1 && p_nras1) begin
      row1      = a1;
      cas_seen1 = 1'b0;
    end
    if (!ncas1 && p_ncas1) cas_seen1 = 1'b1;
    if (nras1 && !p_nras1) begin
      if (tie_stage1 == 1) begin
        check("tie_access_first", 32'(cas_seen1), 32'd1);
        tie_stage1 = 2;
      end else if (tie_stage1 == 2) begin
        check("tie_refresh_next", 32'(cas_seen1), 32'd0);
        tie_stage1 = 0;
      end
      if (!cas_seen1) begin
        check("ref_row", 32'(row1), 32'(exp_row1));
        exp_row1 = exp_row1 + 8'd1;
        nref1++;
      end
    end
    p_nras1 = nras1;
    p_ncas1 = ncas1;
  end

  initial begin
    bus1.req_valid = 1'b1;
    bus1.req_we    = 1'b0;
    bus1.req_addr  = '0;
    bus1.req_wdata = '0;
    forever begin
      @(negedge clk);
      bus1.req_addr  = 14'($urandom);
      bus1.req_we    = 1'($urandom);
      bus1.req_wdata = 16'($urandom);
    end
  end

  // ---------------- overrun instance ----------------
  logic        rst2;
  dram_ctrl_if bus2();
  logic        ovr2, nras2, ncas2, nwe2, ng2, oe2;
  logic [7:0]  a2;
  logic [15:0] dqo2;
  logic [15:0] dqi2 = 16'h0;

  dram_ctrl #(.REF_INTERVAL(16), .T_RFR(20)) u_dut2 (
    .clk(clk), .reset(rst2), .bus(bus2), .ref_overrun(ovr2),
    .nras(nras2), .ncas(ncas2), .nwe(nwe2), .ng(ng2), .a(a2),
    .dq_out(dqo2), .dq_oe(oe2), .dq_in(dqi2)
  );

  // ---------------- main sequence ----------------
  logic [13:0] waddr [12];

  initial begin
    int k;
    bit seen;
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    bus0.req_valid = 1'b0; bus0.req_we = 1'b0; bus0.req_addr = '0; bus0.req_wdata = '0;
    bus2.req_valid = 1'b0; bus2.req_we = 1'b0; bus2.req_addr = '0; bus2.req_wdata = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_nras", 32'(nras0), 32'd1);
    check("rst_ncas", 32'(ncas0), 32'd1);
    check("rst_nwe", 32'(nwe0), 32'd1);
    check("rst_ng", 32'(ng0), 32'd1);
    check("rst_dq_oe", 32'(oe0), 32'd0);
    check("rst_ready", 32'(bus0.req_ready), 32'd0);
    check("rst_rd_valid", 32'(bus0.rd_valid), 32'd0);
    check("rst_rd_data", 32'(bus0.rd_data), 32'd0);
    check("rst_a", 32'(a0), 32'd0);
    check("rst_dq_out", 32'(dqo0), 32'd0);
    check("rst_overrun", 32'(ovr0), 32'd0);
    check("rst_overrun2", 32'(ovr2), 32'd0);
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 32'(bus0.req_ready), 32'd1);

    // Directed write/read with row/column mapping check.
    req0(1'b1, 14'h2A55, 16'hBEEF, 1'b0, 1'b0);
    repeat (6) @(negedge clk);
    check("row_latch", 32'(row0), 32'h55);
    check("col_latch", 32'(col0), 32'h2A);
    req0(1'b0, 14'h2A55, 16'h0, 1'b0, 1'b0);

    // Random writes with random idle gaps, then random read-back.
    for (int i = 0; i < 12; i++) begin
      waddr[i] = 14'($urandom);
      req0(1'b1, waddr[i], 16'($urandom), 1'b0, 1'b0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    for (int i = 0; i < 8; i++) begin
      req0(1'b0, waddr[$urandom_range(0, 11)], 16'h0, 1'b0, 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Back-to-back reads with req_valid held high.
    for (int i = 0; i < 4; i++)
      req0(1'b0, waddr[i], 16'h0, i < 3, i > 0);

    // Reset asserted during CAS of a read.
    @(negedge clk);
    bus0.req_valid = 1'b1; bus0.req_we = 1'b0; bus0.req_addr = 14'h2A55;
    k = 0;
    while (!bus0.req_ready && k < 40) begin @(negedge clk); k++; end
    check("midrst_ready", 32'(bus0.req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus0.req_valid = 1'b0;
    k = 0;
    while (ncas0 && k < 20) begin @(negedge clk); k++; end
    check("midrst_in_cas", 32'(ncas0), 32'd0);
    rst0 = 1'b1;
    @(negedge clk);
    check("midrst_nras", 32'(nras0), 32'd1);
    check("midrst_ncas", 32'(ncas0), 32'd1);
    check("midrst_ng", 32'(ng0), 32'd1);
    rst0 = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (bus0.rd_valid) seen = 1'b1;
    end
    check("midrst_no_rd_valid", 32'(seen), 32'd0);
    req0(1'b0, 14'h2A55, 16'h0, 1'b0, 1'b0);
    check("overrun0", 32'(ovr0), 32'd0);

    // Overrun: sets with long refresh, sticky, cleared by reset only.
    repeat (100) @(negedge clk);
    check("overrun_set", 32'(ovr2), 32'd1);
    repeat (50) @(negedge clk);
    check("overrun_sticky", 32'(ovr2), 32'd1);
    rst2 = 1'b1;
    @(negedge clk);
    check("overrun_rst", 32'(ovr2), 32'd0);
    rst2 = 1'b0;
    repeat (10) @(negedge clk);
    check("overrun_early", 32'(ovr2), 32'd0);
    repeat (40) @(negedge clk);
    check("overrun_reset_again", 32'(ovr2), 32'd1);

    // Refresh ordering instance: run past a full 256-row wrap.
    k = 0;
    while (nref1 < 260 && k < 6000) begin @(negedge clk); k++; end
    check("ref_count", 32'(nref1 >= 260), 32'd1);
    check("tie_seen", 32'(ties1 > 0), 32'd1);
    check("overrun1", 32'(ovr1), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
